// File: rtl/diff_demo_pkg.sv
// Shared types and constants for the PE column issuer.
// Holds the issuer state encoding and the command payload record.
package diff_demo_pkg;

   // Number of activation delta elements in one group
   localparam int GROUP_SIZE = 6;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      ISSUE = 3'd2,
      WAIT  = 3'd3,
      DONE  = 3'd4
   } ISS_state_t;

   // Command payload presented to the column while ctrl_valid is high
   typedef struct packed {
      logic                  bit_mode;
      logic                  kernel_mode;
      logic                  is_odd_row;
      logic                  end_of_row;
      logic [GROUP_SIZE-1:0] guard_map;
   } cmd_t;

endpackage

// File: rtl/pe_col_issuer_guard_gen.sv
// Guard map generator: flags each nonzero element of a group.
// Element i maps to bit (GROUP_SIZE-1-i); dense 4-bit mode forces all ones.
module guard_gen
   import diff_demo_pkg::*;
#(
   parameter int ACT_W = 8
) (
   input  logic [GROUP_SIZE*ACT_W-1:0] data,
   input  logic                        bit_mode,
   output logic [GROUP_SIZE-1:0]       guard_map
);

   // One OR-reduction per element, overridden entirely in bit mode
   always_comb begin
      for (int i = 0; i < GROUP_SIZE; i++) begin
         guard_map[GROUP_SIZE-1-i] = |data[i*ACT_W +: ACT_W];
      end
      if (bit_mode) begin
         guard_map = '1;
      end
   end

endmodule

// File: rtl/pe_col_issuer.sv
// PE column issuer: fetches six-element activation groups and issues one
// column command per group, walking chunks within rows for a whole job.
// Optional feature macro: SKIP_ZERO_GROUP_EN -- all-zero, non-end-of-row
// groups in 8-bit mode are skipped straight from FETCH and counted.
module pe_col_issuer
   import diff_demo_pkg::*;
#(
   parameter int ACT_W = 8,
   parameter int CNT_W = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic                        abort,
   input  logic                        cfg_bit_mode,
   input  logic                        cfg_kernel_mode,
   input  logic [CNT_W-1:0]            cfg_chunks,
   input  logic [CNT_W-1:0]            cfg_rows,
   input  logic                        act_valid,
   output logic                        act_ready,
   input  logic [GROUP_SIZE*ACT_W-1:0] act_data,
   output logic                        ctrl_valid,
   input  logic                        ctrl_ready,
   input  logic                        ctrl_finish,
   output logic                        bit_mode_o,
   output logic                        kernel_mode_o,
   output logic                        is_odd_row_o,
   output logic                        end_of_row_o,
   output logic [GROUP_SIZE-1:0]       guard_map_o,
   output logic                        busy,
   output logic                        done
`ifdef SKIP_ZERO_GROUP_EN
   ,output logic [15:0]                skip_cnt
`endif
);

   ISS_state_t            r_state;
   ISS_state_t            w_next_state;
   logic                  r_bit_mode;
   logic                  r_kernel_mode;
   logic [CNT_W-1:0]      r_chunks;
   logic [CNT_W-1:0]      r_rows;
   logic [CNT_W-1:0]      r_chunk_cnt;
   logic [CNT_W-1:0]      r_row_cnt;
   cmd_t                  r_cmd;
   logic [GROUP_SIZE-1:0] w_guard_map;
   logic                  w_start_acc;
   logic                  w_capture;
   logic                  w_last_chunk;
   logic                  w_last_row;
   logic                  w_skip;
   logic                  w_advance;

   guard_gen #(.ACT_W(ACT_W)) u_guard_gen (
      .data      (act_data),
      .bit_mode  (r_bit_mode),
      .guard_map (w_guard_map)
   );

   assign w_start_acc  = (r_state == IDLE) && start;
   assign w_capture    = (r_state == FETCH) && act_valid;
   assign w_last_chunk = (r_chunk_cnt == r_chunks - CNT_W'(1));
   assign w_last_row   = (r_row_cnt == r_rows - CNT_W'(1));

`ifdef SKIP_ZERO_GROUP_EN
   assign w_skip = w_capture && (w_guard_map == '0) && !r_bit_mode && !w_last_chunk;
`else
   assign w_skip = 1'b0;
`endif

   // A group completes on finish in WAIT, on ready+finish together in ISSUE,
   // or when it is skipped at capture
   assign w_advance = ((r_state == ISSUE) && ctrl_ready && ctrl_finish) ||
                      ((r_state == WAIT) && ctrl_finish) || w_skip;

   // State register; abort and reset both drop the job back to IDLE
   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n || abort) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:  if (start) w_next_state = FETCH;
         FETCH: if (act_valid && !w_skip) w_next_state = ISSUE;
         ISSUE: begin
            if (ctrl_ready) begin
               if (!ctrl_finish)                    w_next_state = WAIT;
               else if (w_last_chunk && w_last_row) w_next_state = DONE;
               else                                 w_next_state = FETCH;
            end
         end
         WAIT: begin
            if (ctrl_finish) begin
               w_next_state = (w_last_chunk && w_last_row) ? DONE : FETCH;
            end
         end
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Handshake and status outputs decoded from the current state
   always_comb begin
      act_ready  = (r_state == FETCH);
      ctrl_valid = (r_state == ISSUE);
      busy       = (r_state != IDLE);
      done       = (r_state == DONE) && !abort;
   end

   // Job configuration, chunk/row counters and the captured command payload
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_bit_mode    <= 1'b0;
         r_kernel_mode <= 1'b0;
         r_chunks      <= '0;
         r_rows        <= '0;
         r_chunk_cnt   <= '0;
         r_row_cnt     <= '0;
         r_cmd         <= '0;
      end else if (w_start_acc) begin
         r_bit_mode    <= cfg_bit_mode;
         r_kernel_mode <= cfg_kernel_mode;
         r_chunks      <= (cfg_chunks == '0) ? CNT_W'(1) : cfg_chunks;
         r_rows        <= (cfg_rows == '0) ? CNT_W'(1) : cfg_rows;
         r_chunk_cnt   <= '0;
         r_row_cnt     <= '0;
      end else begin
         if (w_capture) begin
            r_cmd <= '{bit_mode:    r_bit_mode,
                       kernel_mode: r_kernel_mode,
                       is_odd_row:  ~r_row_cnt[0],
                       end_of_row:  w_last_chunk,
                       guard_map:   w_guard_map};
         end
         if (w_advance) begin
            if (w_last_chunk) begin
               r_chunk_cnt <= '0;
               r_row_cnt   <= r_row_cnt + CNT_W'(1);
            end else begin
               r_chunk_cnt <= r_chunk_cnt + CNT_W'(1);
            end
         end
      end
   end

   assign bit_mode_o    = r_cmd.bit_mode;
   assign kernel_mode_o = r_cmd.kernel_mode;
   assign is_odd_row_o  = r_cmd.is_odd_row;
   assign end_of_row_o  = r_cmd.end_of_row;
   assign guard_map_o   = r_cmd.guard_map;

`ifdef SKIP_ZERO_GROUP_EN
   logic [15:0] r_skip_cnt;

   // Saturating count of skipped groups, cleared when a job starts
   always_ff @(posedge clk) begin
      if (!rst_n || w_start_acc) begin
         r_skip_cnt <= '0;
      end else if (w_skip && (r_skip_cnt != 16'hFFFF)) begin
         r_skip_cnt <= r_skip_cnt + 16'd1;
      end
   end

   assign skip_cnt = r_skip_cnt;
`endif

endmodule

// File: doc/pe_col_issuer.md
PE_COL_ISSUER -- requirements
Module: pe_col_issuer

Interface
REQ-001 SHALL have parameter ACT_W, default 8, width of one activation delta element.
REQ-002 SHALL have parameter CNT_W, default 8, width of the row and chunk configuration and counters.
REQ-003 SHALL have clk  input  1  sole clock, all logic on its rising edge.
REQ-004 SHALL have rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have start  input  1  job start pulse; cfg_* sampled when it is accepted.
REQ-006 SHALL have abort  input  1  synchronous job cancel.
REQ-007 SHALL have cfg_bit_mode  input  1  1 = 4-bit dense mode.
REQ-008 SHALL have cfg_kernel_mode  input  1  kernel mode forwarded to the column.
REQ-009 SHALL have cfg_chunks / cfg_rows  input  CNT_W each  six-element groups per row / rows per job.
REQ-010 SHALL have act_valid  input  1,  act_ready  output  1,  act_data  input  6*ACT_W  (element 0 in LSBs).
REQ-011 SHALL have ctrl_valid  output  1,  ctrl_ready  input  1,  ctrl_finish  input  1  (column control handshake).
REQ-012 SHALL have bit_mode_o, kernel_mode_o, is_odd_row_o, end_of_row_o  output  1 each, and guard_map_o  output  6  (command payload).
REQ-013 SHALL have busy  output  1 and done  output  1 (one-cycle pulse).

Function
REQ-014 SHALL implement states IDLE, FETCH, ISSUE, WAIT, DONE.
REQ-015 IDLE: start=1 SHALL latch cfg_* (a value of 0 in cfg_chunks or cfg_rows is treated as 1), clear counters, and go to FETCH; start SHALL be ignored in every other state.
REQ-016 FETCH: act_ready=1; on act_valid SHALL capture the payload and go to ISSUE in the next cycle.
REQ-017 guard_map bit (5-i) SHALL be 1 when element i is nonzero, for i=0..5; when bit mode is set, guard_map SHALL be 6'b111111.
REQ-018 is_odd_row_o SHALL be 1 for rows 0, 2, 4, ... counting from 0 (the first row is odd); end_of_row_o SHALL be 1 only for chunk index cfg_chunks-1.
REQ-019 ISSUE: ctrl_valid=1 with the payload stable until ctrl_ready=1; on ctrl_ready=1, ctrl_finish=1 in the same cycle SHALL advance exactly as WAIT does, else go to WAIT.
REQ-020 WAIT: ctrl_valid=0; on ctrl_finish the block SHALL increment the chunk counter, wrap it to 0 after cfg_chunks-1 and increment the row counter, then go to DONE after the last chunk of the last row, else to FETCH.
REQ-021 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 abort=1 SHALL force IDLE in the next cycle from any state, with done=0; a WAIT in progress SHALL be dropped.
REQ-024 ctrl_finish received outside ISSUE and WAIT SHALL be ignored.
REQ-025 act_ready and ctrl_valid SHALL never be 1 in the same cycle.

Reset
REQ-026 rst_n=0 at a clock edge SHALL set: state IDLE; all outputs 0 (act_ready, ctrl_valid, busy, done, guard_map_o, bit_mode_o, kernel_mode_o, is_odd_row_o, end_of_row_o); counters and latched configuration 0.
REQ-027 Reset asserted mid-job SHALL behave exactly as an abort, with no done pulse.

Configuration
REQ-028 With SKIP_ZERO_GROUP_EN defined, a fetched group SHALL skip ISSUE and advance the counters directly from FETCH in the cycle after capture when its guard_map is 0, bit mode is 0 and it is not an end-of-row chunk.
REQ-029 With SKIP_ZERO_GROUP_EN defined, a 16-bit saturating output skip_cnt SHALL count skipped groups and clear on start.
REQ-030 Without SKIP_ZERO_GROUP_EN, every group SHALL be issued, and skip_cnt SHALL NOT exist.

Structure
REQ-031 The state enum ISS_state_t and the constant GROUP_SIZE=6 SHALL reside in diff_demo_pkg.
REQ-032 guard_map generation SHALL be a combinational sub-module named guard_gen, with inputs data and bit_mode and output guard_map.

Verification
REQ-033 cfg_rows=1, cfg_chunks=2, 8-bit mode, data elements {0,3,0,0,0,7} -> guard_map_o=6'b010001; end_of_row_o is 0 on the first command and 1 on the second; done pulses once.
REQ-034 4-bit mode with all-zero data -> guard_map_o=6'b111111 and bit_mode_o=1 on every command.
REQ-035 cfg_rows=3, cfg_chunks=1 -> is_odd_row_o sequence 1,0,1; end_of_row_o=1 on all three commands.
REQ-036 ctrl_ready held 0 for 5 cycles -> ctrl_valid stays 1 with the payload unchanged; ctrl_ready and ctrl_finish in the same cycle -> the next act_ready follows in the next cycle.
REQ-037 abort in WAIT -> IDLE next cycle, busy=0, no done pulse; a following start runs a full job correctly.
REQ-038 With SKIP_ZERO_GROUP_EN: cfg_chunks=3, 8-bit mode, groups zero/zero/zero -> only the third (end-of-row) group is issued, and skip_cnt=2.
